cla_seq_adder_display: RTL and testbench

//   Parametrised WIDTH-bit adder/subtractor/accumulator built from 4-bit carry-look-ahead groups.

---
 rtl/cla_seq_adder_display_pkg.sv | 23 ++
 rtl/cla_seq_adder_display_cla4_group.sv | 31 +++
 rtl/cla_seq_adder_display.sv | 154 +++++++++++++++
 tb/tb_cla_seq_adder_display.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_adder_display_pkg.sv
// Shared definitions for the sequential CLA adder with 7-segment display:
// controller state encoding and the hex-digit to segment lookup.
package cla_seq_adder_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}, indexed by nibble value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hexToSeg(input logic [3:0] value);
        return HEX_SEG[value];
    endfunction

endpackage

// File: rtl/cla_seq_adder_display_cla4_group.sv
// One 4-bit carry-look-ahead group. Every internal carry is expanded directly
// from the per-bit generate/propagate terms, so no carry ripples inside the group.
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;

    // Generate/propagate terms, look-ahead carries and the sum bits
    always_comb begin
        w_g  = a & b;
        w_p  = a ^ b;
        w_c1 = w_g[0] | (w_p[0] & ci);
        w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
        c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & ci);
        co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);
        s    = w_p ^ {c3, w_c2, w_c1, ci};
    end

endmodule

// File: rtl/cla_seq_adder_display.sv
// Sequential WIDTH-bit adder/subtractor/accumulator. One 4-bit CLA group is
// evaluated per clock (LSB group first) with the carry held in a register
// between groups; the registered result is shown on a multiplexed hex display.
module cla_seq_adder_display
    import cla_seq_adder_display_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SCAN_DIV = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               cin,
    input  logic               sub,
    input  logic               acc_mode,
    output logic               out_valid,
    output logic [WIDTH-1:0]   sum,
    output logic               cout,
    output logic               ovf,
    output logic [WIDTH/4-1:0] an,
    output logic [6:0]         seg,
    output logic               dp
);

    localparam int G  = WIDTH / 4;
    localparam int KW = (G > 1) ? $clog2(G) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(G - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [KW-1:0]       r_k;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_c;
    logic [WIDTH-1:0]    r_sum;
    logic                r_cout;
    logic                r_ovf;
    logic                r_outValid;
    logic [SCAN_DIV-1:0] r_scan;

    logic                w_accept;
    logic [3:0]          w_ga;
    logic [3:0]          w_gb;
    logic [3:0]          w_s;
    logic                w_co;
    logic                w_c3;
    logic [KW-1:0]       w_digit;
    logic [G-1:0]        w_an;
    logic [6:0]          w_seg;
    logic                w_dp;

    assign in_ready  = (r_state != ST_CALC);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_outValid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign an        = w_an;
    assign seg       = w_seg;
    assign dp        = w_dp;

    assign w_ga = r_a[4*r_k +: 4];
    assign w_gb = r_b[4*r_k +: 4];

    cla4_group u_group (
        .a  (w_ga),
        .b  (w_gb),
        .ci (r_c),
        .s  (w_s),
        .co (w_co),
        .c3 (w_c3)
    );

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state logic: DONE only leaves on a new accept, never back to IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nextState = ST_CALC;
            ST_CALC: if (r_k == K_LAST) w_nextState = ST_DONE;
            ST_DONE: if (w_accept) w_nextState = ST_CALC;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Operand capture on accept, then one group of the sum per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= 1'b0;
            r_k        <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_outValid <= 1'b0;
        end else if (w_accept) begin
            r_a        <= acc_mode ? r_sum : op_a;
            r_b        <= op_b ^ {WIDTH{sub}};
            r_c        <= cin ^ sub;
            r_k        <= '0;
            r_outValid <= 1'b0;
        end else if (r_state == ST_CALC) begin
            r_sum[4*r_k +: 4] <= w_s;
            r_c               <= w_co;
            r_k               <= r_k + 1'b1;
            if (r_k == K_LAST) begin
                r_cout     <= w_co;
                r_ovf      <= w_c3 ^ w_co;
                r_outValid <= 1'b1;
            end
        end
    end

    // Free-running scan counter driving the digit multiplexer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_scan <= '0;
        else     r_scan <= r_scan + 1'b1;
    end

    // Digit index from the counter's top bits, folded back into 0..G-1
    generate
        if (G == 1) begin : g_oneDigit
            assign w_digit = '0;
        end else if ((1 << KW) == G) begin : g_pow2Digits
            assign w_digit = r_scan[SCAN_DIV-1 -: KW];
        end else begin : g_foldDigits
            logic [KW-1:0] w_digitRaw;
            assign w_digitRaw = r_scan[SCAN_DIV-1 -: KW];
            assign w_digit    = (w_digitRaw >= KW'(G)) ? (w_digitRaw - KW'(G)) : w_digitRaw;
        end
    endgenerate

    // Display drive: blanked during reset, otherwise the selected nibble of sum
    always_comb begin
        w_an  = '1;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        if (!rst) begin
            w_an[w_digit] = 1'b0;
            w_seg         = hexToSeg(r_sum[4*w_digit +: 4]);
            w_dp          = !((w_digit == '0) && r_cout);
        end
    end

endmodule

// File: tb/tb_cla_seq_adder_display.sv
// Directed self-checking bench for cla_seq_adder_display (WIDTH=16, SCAN_DIV=4).
module tb_cla_seq_adder_display;

    localparam int WIDTH    = 16;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        sub;
    logic        acc_mode;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int compared   = 0;
    int mismatched = 0;

    cla_seq_adder_display #(
        .WIDTH    (WIDTH),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .acc_mode  (acc_mode),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts, asserts and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] comparison %s", tag);
        end
    endtask

    // Drive one set of inputs just after a falling edge
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s, input logic acc);
        @(negedge clk);
        in_valid = v;
        op_a     = a;
        op_b     = b;
        cin      = c;
        sub      = s;
        acc_mode = acc;
    endtask

    // One complete operation: accept, check out_valid timing, then the result
    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s, input logic acc,
                         input logic [15:0] expSum, input logic expCout, input logic expOvf);
        applyStimulus(1'b1, a, b, c, s, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput({tag, "_readyInCalc"}, 32'(in_ready), 32'd0);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s_validEdge%0d", tag, e), 32'(out_valid), 32'(e == 4));
        end
        checkOutput({tag, "_sum"},  32'(sum),      32'(expSum));
        checkOutput({tag, "_cout"}, 32'(cout),     32'(expCout));
        checkOutput({tag, "_ovf"},  32'(ovf),      32'(expOvf));
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Wait (bounded) until the given digit is being scanned
    task automatic waitDigit(input string tag, input int d);
        logic [3:0] wantAn;
        bit         found;
        wantAn = ~(4'b0001 << d);
        found  = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === wantAn) found = 1'b1;
        end
        checkOutput({tag, "_digitFound"}, 32'(an), 32'(wantAn));
    endtask

    initial begin
        int rises;
        rst      = 1'b1;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        cin      = 1'b0;
        sub      = 1'b0;
        acc_mode = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rstAn",    32'(an),        32'hF);
        checkOutput("rstSeg",   32'(seg),       32'h7F);
        checkOutput("rstDp",    32'(dp),        32'd1);
        checkOutput("rstSum",   32'(sum),       32'h0);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstReady", 32'(in_ready),  32'd1);
        rst = 1'b0;
        #1;
        checkOutput("firstDigitAn",  32'(an),  32'hE);
        checkOutput("firstDigitSeg", 32'(seg), 32'h40);

        runOp("add",   16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        runOp("ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        runOp("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        waitDigit("carryD0", 0);
        checkOutput("carryD0Seg", 32'(seg), 32'h40);
        checkOutput("carryD0Dp",  32'(dp),  32'd0);

        runOp("sub",   16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        runOp("zero",  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Back-to-back accumulation with in_valid held high throughout
        applyStimulus(1'b1, 16'hAAAA, 16'h0003, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) begin
            checkOutput($sformatf("acc%0d_validDrop", r), 32'(out_valid), 32'd0);
            checkOutput($sformatf("acc%0d_readyCalc", r), 32'(in_ready),  32'd0);
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            checkOutput($sformatf("acc%0d_valid", r), 32'(out_valid), 32'd1);
            checkOutput($sformatf("acc%0d_sum", r),   32'(sum),       32'(16'(3 * (r + 1))));
            if (r < 2) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        acc_mode = 1'b0;

        // Abort: reset during the second CALC cycle
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abortAn",    32'(an),        32'hF);
        checkOutput("abortSeg",   32'(seg),       32'h7F);
        checkOutput("abortDp",    32'(dp),        32'd1);
        checkOutput("abortSum",   32'(sum),       32'h0);
        checkOutput("abortValid", 32'(out_valid), 32'd0);
        checkOutput("abortReady", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abortFirstAn",  32'(an),  32'hE);
        checkOutput("abortFirstSeg", 32'(seg), 32'h40);
        rises = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        checkOutput("abortNoValid", 32'(rises), 32'd0);

        // Display of a known value
        runOp("disp", 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);
        waitDigit("dispD0", 0);
        checkOutput("dispD0Seg", 32'(seg), 32'h19);
        checkOutput("dispD0Dp",  32'(dp),  32'd1);
        waitDigit("dispD1", 1);
        checkOutput("dispD1Seg", 32'(seg), 32'h30);
        waitDigit("dispD3", 3);
        checkOutput("dispD3Seg", 32'(seg), 32'h79);
        checkOutput("dispD3Dp",  32'(dp),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
